alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
// - ID->EX issue stage. Decodes a fetched MIPS word plus register-file read data into the 6-bit ALU op code, A/B operands and write-back control for the EX-stage ALU.
// - Registered, two-entry skid buffer with valid/ready on both sides. Upstream decode can run while EX is stalled; no combinational ready path.
// PARAMETERS
// - OPW    6   ALU op-code width; codes are the `ALU_* macros in macro.vh
// - DW     32  datapath width
// - RW     5   register-index width
// PORTS
// - clk          in   1     rising-edge clock
// - rst          in   1     asynchronous, active-high reset
// - in_valid     in   1     upstream presents instruction
// - in_ready     out  1     stage can accept (registered)
// - in_instr     in   32    instruction word
// - in_rs_val    in   DW    GPR[rs]
// - in_rt_val    in   DW    GPR[rt]
// - flush        in   1     kill all held entries (branch/exception)
// - out_valid    out  1     head entry valid to EX
// - out_ready    in   1     EX accepts head entry
// - out_aluop    out  OPW   ALU op code
// - out_a        out  DW    ALU operand A
// - out_b        out  DW    ALU operand B
// - out_wr_en    out  1     result written to GPR
// - out_wr_reg   out  RW    destination register
// - out_illegal  out  1     unsupported encoding
// BEHAVIOUR
// - Decode (op=instr[31:26], fn=instr[5:0], se/ze = sign/zero-extended instr[15:0], sh={27'b0,instr[10:6]}):
//   op 0: fn 20 ADD,21 ADDU,22 SUB,23 SUBU,24 AND,25 OR,26 XOR,27 NOR,2A SLT,2B SLTU -> A=rs,B=rt.
//   fn 00 SLL,02 SRL,03 SRA -> A=sh, B=rt. fn 04 SLLV,06 SRLV,07 SRAV -> A=rs&32'h1F, B=rt.
//   fn 08 JR -> A=rs, B=0, wr_en=0. All other R-type: wr_en=rd!=0.
//   op 08 ADDI,09 ADDIU,0A SLTI,0B SLTIU -> B=se. 0C ANDI->ALU_AND, 0D ORI, 0E XORI -> B=ze.
//   op 0F LUI -> A=0, B=ze. I-type: A=rs, wr_reg=rt, wr_en=rt!=0.
//   op 23 LW, 2B SW -> ALU_ADDU, A=rs, B=se, wr_en=0 (memory stage owns write-back).
//   Anything else: illegal=1, aluop=`ALU_ADDU, A=B=0, wr_en=0. wr_reg=0 whenever wr_en=0.
// - Decode is combinational on in_* and captured only on accept (in_valid & in_ready).
// - FSM on occupancy: EMPTY(0), ONE(1), TWO(2). Head reg drives out_*, skid reg holds second.
//   EMPTY: accept -> ONE (head<=decode). Latency: accept at edge N -> out_valid at N+1.
//   ONE: accept&pop -> ONE (head<=decode); accept only -> TWO (skid<=decode); pop only -> EMPTY.
//   TWO: in_ready=0; pop -> ONE (head<=skid). Never accepts in TWO.
// - in_ready = (state!=TWO), registered from next-state; pop = out_valid & out_ready.
// - Order strictly FIFO; an entry is presented until popped; out_* stable while out_valid & !out_ready.
// - flush: next state EMPTY, in_ready=1 next cycle; same-cycle accept and pop are discarded; flush wins over all.
// - Reset (async): state=EMPTY, in_ready=0 during reset, 1 on first clock after deassert; out_valid=0, out_aluop=0,
//   out_a=out_b=0, out_wr_en=0, out_wr_reg=0, out_illegal=0. Reset mid-transfer drops all entries.
// - out_* other than out_valid are don't-care for EX when out_valid=0 but must be held, not X, in sim.
// TESTING
// - Reset, then 0x012A4020 (add $8,$9,$10), rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, aluop=`ALU_ADD, A=5, B=7, wr_reg=8, wr_en=1.
// - 0x2128FFFF (addi $8,$9,-1), rs=3 -> aluop=`ALU_ADDI, B=32'hFFFFFFFF; 0x3528FFFF (ori) -> B=32'h0000FFFF.
// - 0x00084100 (sll $8,$8,4), rt=1 -> A=4, B=1; 0x3C081234 (lui) -> A=0, B=32'h1234, wr_reg=8.
// - out_ready=0, push 3 back-to-back -> 2 accepted, in_ready=0 after 2nd; release out_ready -> FIFO order kept, 3rd accepted.
// - flush while TWO with in_valid=1 -> out_valid=0 next cycle, in_ready=1, neither held nor incoming word appears.
// - Illegal 0xFC000000 -> illegal=1, wr_en=0; async rst pulse mid-stall -> all outputs to reset values immediately.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : ID->EX issue stage; MIPS decode into a two-entry registered skid buffer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ALU_ADD
`define ALU_ADD   6'h01
`define ALU_ADDU  6'h02
`define ALU_SUB   6'h03
`define ALU_SUBU  6'h04
`define ALU_AND   6'h05
`define ALU_OR    6'h06
`define ALU_XOR   6'h07
`define ALU_NOR   6'h08
`define ALU_SLT   6'h09
`define ALU_SLTU  6'h0A
`define ALU_SLL   6'h0B
`define ALU_SRL   6'h0C
`define ALU_SRA   6'h0D
`define ALU_SLLV  6'h0E
`define ALU_SRLV  6'h0F
`define ALU_SRAV  6'h10
`define ALU_JR    6'h11
`define ALU_ADDI  6'h12
`define ALU_ADDIU 6'h13
`define ALU_SLTI  6'h14
`define ALU_SLTIU 6'h15
`define ALU_ORI   6'h16
`define ALU_XORI  6'h17
`define ALU_LUI   6'h18
`endif

module alu_issue_stage #(
  parameter int OPW = 6,
  parameter int DW  = 32,
  parameter int RW  = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    in_instr,
  input  logic [DW-1:0]  in_rs_val,
  input  logic [DW-1:0]  in_rt_val,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] out_aluop,
  output logic [DW-1:0]  out_a,
  output logic [DW-1:0]  out_b,
  output logic           out_wr_en,
  output logic [RW-1:0]  out_wr_reg,
  output logic           out_illegal
);

  typedef struct packed {
    logic [OPW-1:0] aluop;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic           wr_en;
    logic [RW-1:0]  wr_reg;
    logic           illegal;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t  r_state;
  state_t  w_next;
  logic    r_in_ready;
  entry_t  r_head;
  entry_t  r_skid;
  entry_t  w_dec;
  logic    w_accept;
  logic    w_pop;
  logic    w_ld_head;
  logic    w_head_from_skid;
  logic    w_ld_skid;

  logic [5:0]    w_op;
  logic [5:0]    w_fn;
  logic [DW-1:0] w_se;
  logic [DW-1:0] w_ze;
  logic [DW-1:0] w_sh;
  logic [RW-1:0] w_rd;
  logic [RW-1:0] w_rt;
  logic          w_wants_wr;
  logic          w_unused;

  assign w_op     = in_instr[31:26];
  assign w_fn     = in_instr[5:0];
  assign w_se     = {{(DW-16){in_instr[15]}}, in_instr[15:0]};
  assign w_ze     = {{(DW-16){1'b0}}, in_instr[15:0]};
  assign w_sh     = {{(DW-5){1'b0}}, in_instr[10:6]};
  assign w_rd     = RW'(in_instr[15:11]);
  assign w_rt     = RW'(in_instr[20:16]);
  // rs index is not needed: the register file already supplied its value
  assign w_unused = ^in_instr[25:21];

  always_comb begin
    w_dec         = '0;
    w_dec.aluop   = `ALU_ADDU;
    w_wants_wr    = 1'b0;
    if (w_op == 6'h00) begin
      w_dec.a      = in_rs_val;
      w_dec.b      = in_rt_val;
      w_dec.wr_reg = w_rd;
      w_wants_wr   = 1'b1;
      case (w_fn)
        6'h20: w_dec.aluop = `ALU_ADD;
        6'h21: w_dec.aluop = `ALU_ADDU;
        6'h22: w_dec.aluop = `ALU_SUB;
        6'h23: w_dec.aluop = `ALU_SUBU;
        6'h24: w_dec.aluop = `ALU_AND;
        6'h25: w_dec.aluop = `ALU_OR;
        6'h26: w_dec.aluop = `ALU_XOR;
        6'h27: w_dec.aluop = `ALU_NOR;
        6'h2A: w_dec.aluop = `ALU_SLT;
        6'h2B: w_dec.aluop = `ALU_SLTU;
        6'h00: begin w_dec.aluop = `ALU_SLL;  w_dec.a = w_sh; end
        6'h02: begin w_dec.aluop = `ALU_SRL;  w_dec.a = w_sh; end
        6'h03: begin w_dec.aluop = `ALU_SRA;  w_dec.a = w_sh; end
        6'h04: begin w_dec.aluop = `ALU_SLLV; w_dec.a = {{(DW-5){1'b0}}, in_rs_val[4:0]}; end
        6'h06: begin w_dec.aluop = `ALU_SRLV; w_dec.a = {{(DW-5){1'b0}}, in_rs_val[4:0]}; end
        6'h07: begin w_dec.aluop = `ALU_SRAV; w_dec.a = {{(DW-5){1'b0}}, in_rs_val[4:0]}; end
        6'h08: begin w_dec.aluop = `ALU_JR;   w_dec.b = '0; w_wants_wr = 1'b0; end
        default: w_dec.illegal = 1'b1;
      endcase
    end else begin
      w_dec.a      = in_rs_val;
      w_dec.b      = w_se;
      w_dec.wr_reg = w_rt;
      w_wants_wr   = 1'b1;
      case (w_op)
        6'h08: w_dec.aluop = `ALU_ADDI;
        6'h09: w_dec.aluop = `ALU_ADDIU;
        6'h0A: w_dec.aluop = `ALU_SLTI;
        6'h0B: w_dec.aluop = `ALU_SLTIU;
        6'h0C: begin w_dec.aluop = `ALU_AND;  w_dec.b = w_ze; end
        6'h0D: begin w_dec.aluop = `ALU_ORI;  w_dec.b = w_ze; end
        6'h0E: begin w_dec.aluop = `ALU_XORI; w_dec.b = w_ze; end
        6'h0F: begin w_dec.aluop = `ALU_LUI;  w_dec.a = '0; w_dec.b = w_ze; end
        // memory stage owns write-back for loads and stores
        6'h23, 6'h2B: begin w_dec.aluop = `ALU_ADDU; w_wants_wr = 1'b0; end
        default: w_dec.illegal = 1'b1;
      endcase
    end
    if (w_dec.illegal) begin
      w_dec.aluop = `ALU_ADDU;
      w_dec.a     = '0;
      w_dec.b     = '0;
      w_wants_wr  = 1'b0;
    end
    w_dec.wr_en = w_wants_wr && (w_dec.wr_reg != '0);
    if (!w_dec.wr_en) begin
      w_dec.wr_reg = '0;
    end
  end

  assign w_accept = in_valid && r_in_ready;
  assign w_pop    = out_valid && out_ready;

  always_comb begin
    w_next           = r_state;
    w_ld_head        = 1'b0;
    w_head_from_skid = 1'b0;
    w_ld_skid        = 1'b0;
    if (flush) begin
      w_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) begin
          w_next    = S_ONE;
          w_ld_head = 1'b1;
        end
        S_ONE: if (w_accept && w_pop) begin
          w_ld_head = 1'b1;
        end else if (w_accept) begin
          w_next    = S_TWO;
          w_ld_skid = 1'b1;
        end else if (w_pop) begin
          w_next = S_EMPTY;
        end
        S_TWO: if (w_pop) begin
          w_next           = S_ONE;
          w_ld_head        = 1'b1;
          w_head_from_skid = 1'b1;
        end
        default: w_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
      r_head     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != S_TWO);
      if (w_ld_head) begin
        r_head <= w_head_from_skid ? r_skid : w_dec;
      end
      if (w_ld_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != S_EMPTY);
  assign out_aluop   = r_head.aluop;
  assign out_a       = r_head.a;
  assign out_b       = r_head.b;
  assign out_wr_en   = r_head.wr_en;
  assign out_wr_reg  = r_head.wr_reg;
  assign out_illegal = r_head.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed spec cases plus random traffic against a queue model.
`default_nettype none

`ifndef ALU_ADD
`define ALU_ADD   6'h01
`define ALU_ADDU  6'h02
`define ALU_SUB   6'h03
`define ALU_SUBU  6'h04
`define ALU_AND   6'h05
`define ALU_OR    6'h06
`define ALU_XOR   6'h07
`define ALU_NOR   6'h08
`define ALU_SLT   6'h09
`define ALU_SLTU  6'h0A
`define ALU_SLL   6'h0B
`define ALU_SRL   6'h0C
`define ALU_SRA   6'h0D
`define ALU_SLLV  6'h0E
`define ALU_SRLV  6'h0F
`define ALU_SRAV  6'h10
`define ALU_JR    6'h11
`define ALU_ADDI  6'h12
`define ALU_ADDIU 6'h13
`define ALU_SLTI  6'h14
`define ALU_SLTIU 6'h15
`define ALU_ORI   6'h16
`define ALU_XORI  6'h17
`define ALU_LUI   6'h18
`endif

module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_rs_val = '0;
  logic [31:0] in_rt_val = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_aluop;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_wr_en;
  logic [4:0]  out_wr_reg;
  logic        out_illegal;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
    .out_a(out_a), .out_b(out_b), .out_wr_en(out_wr_en),
    .out_wr_reg(out_wr_reg), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        we;
    logic [4:0]  wr;
    logic        ill;
  } ent_t;

  ent_t q[$];
  bit   m_ready = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode, written from the instruction-set rules
  function automatic ent_t ref_dec(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
    ent_t e;
    int   op = int'(w[31:26]);
    int   fn = int'(w[5:0]);
    int   rd = int'(w[15:11]);
    int   rtn = int'(w[20:16]);
    logic [31:0] imm_s = 32'(signed'(w[15:0]));
    logic [31:0] imm_z = 32'(w[15:0]);
    int   dest = 0;
    bit   writes = 0;
    e = '{op: `ALU_ADDU, a: 0, b: 0, we: 0, wr: 0, ill: 1};
    if (op == 0) begin
      e.ill = 0; e.a = rs; e.b = rt; dest = rd; writes = 1;
      case (fn)
        'h20: e.op = `ALU_ADD;  'h21: e.op = `ALU_ADDU; 'h22: e.op = `ALU_SUB;
        'h23: e.op = `ALU_SUBU; 'h24: e.op = `ALU_AND;  'h25: e.op = `ALU_OR;
        'h26: e.op = `ALU_XOR;  'h27: e.op = `ALU_NOR;  'h2A: e.op = `ALU_SLT;
        'h2B: e.op = `ALU_SLTU;
        'h00: begin e.op = `ALU_SLL; e.a = 32'(w[10:6]); end
        'h02: begin e.op = `ALU_SRL; e.a = 32'(w[10:6]); end
        'h03: begin e.op = `ALU_SRA; e.a = 32'(w[10:6]); end
        'h04: begin e.op = `ALU_SLLV; e.a = rs % 32; end
        'h06: begin e.op = `ALU_SRLV; e.a = rs % 32; end
        'h07: begin e.op = `ALU_SRAV; e.a = rs % 32; end
        'h08: begin e.op = `ALU_JR; e.b = 0; writes = 0; end
        default: e.ill = 1;
      endcase
    end else begin
      e.ill = 0; e.a = rs; e.b = imm_s; dest = rtn; writes = 1;
      case (op)
        'h08: e.op = `ALU_ADDI;  'h09: e.op = `ALU_ADDIU;
        'h0A: e.op = `ALU_SLTI;  'h0B: e.op = `ALU_SLTIU;
        'h0C: begin e.op = `ALU_AND;  e.b = imm_z; end
        'h0D: begin e.op = `ALU_ORI;  e.b = imm_z; end
        'h0E: begin e.op = `ALU_XORI; e.b = imm_z; end
        'h0F: begin e.op = `ALU_LUI;  e.a = 0; e.b = imm_z; end
        'h23, 'h2B: begin e.op = `ALU_ADDU; writes = 0; end
        default: e.ill = 1;
      endcase
    end
    if (e.ill) begin
      e.op = `ALU_ADDU; e.a = 0; e.b = 0; writes = 0;
    end
    e.we = writes && dest != 0;
    e.wr = e.we ? 5'(dest) : 5'd0;
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0] rfn [11] = '{6'h20, 6'h22, 6'h25, 6'h27, 6'h2B, 6'h00, 6'h03, 6'h04, 6'h07, 6'h08, 6'h3F};
    logic [5:0] iop [11] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
    logic [31:0] w = $urandom;
    int k = int'($urandom_range(0, 9));
    if (k < 5) begin
      w[31:26] = 6'h00;
      w[5:0]   = rfn[$urandom_range(0, 10)];
    end else if (k < 9) begin
      w[31:26] = iop[$urandom_range(0, 10)];
    end
    return w;
  endfunction

  task automatic compare();
    ent_t h;
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      h = q[0];
      chk("aluop", 32'(out_aluop), 32'(h.op));
      chk("a", out_a, h.a);
      chk("b", out_b, h.b);
      chk("wr_en", 32'(out_wr_en), 32'(h.we));
      chk("wr_reg", 32'(out_wr_reg), 32'(h.wr));
      chk("illegal", 32'(out_illegal), 32'(h.ill));
    end
  endtask

  // One clock: update the model at the rising edge, check at the falling edge
  task automatic tick();
    ent_t e;
    bit   acc;
    bit   pop;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ready = 1'b0;
    end else begin
      acc = in_valid && m_ready;
      pop = (q.size() != 0) && out_ready;
      e   = ref_dec(in_instr, in_rs_val, in_rt_val);
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      m_ready = (q.size() < 2);
    end
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = 1'b1; in_instr = w; in_rs_val = rs; in_rt_val = rt;
  endtask

  task automatic push(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
    drive(w, rs, rt);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_aluop"}, 32'(out_aluop), 32'd0);
    chk({tag, "_a"}, out_a, 32'd0);
    chk({tag, "_b"}, out_b, 32'd0);
    chk({tag, "_wr_en"}, 32'(out_wr_en), 32'd0);
    chk({tag, "_wr_reg"}, 32'(out_wr_reg), 32'd0);
    chk({tag, "_illegal"}, 32'(out_illegal), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk_reset_outputs("rst");
    rst = 1'b0;
    tick();

    out_ready = 1'b1;
    push(32'h012A4020, 32'd5, 32'd7);
    chk("add_aluop", 32'(out_aluop), 32'(`ALU_ADD));
    chk("add_a", out_a, 32'd5);
    chk("add_b", out_b, 32'd7);
    chk("add_wr_reg", 32'(out_wr_reg), 32'd8);
    chk("add_wr_en", 32'(out_wr_en), 32'd1);

    push(32'h2128FFFF, 32'd3, 32'd0);
    chk("addi_aluop", 32'(out_aluop), 32'(`ALU_ADDI));
    chk("addi_b", out_b, 32'hFFFFFFFF);
    push(32'h3528FFFF, 32'd3, 32'd0);
    chk("ori_b", out_b, 32'h0000FFFF);
    push(32'h00084100, 32'd9, 32'd1);
    chk("sll_a", out_a, 32'd4);
    chk("sll_b", out_b, 32'd1);
    push(32'h3C081234, 32'd77, 32'd0);
    chk("lui_a", out_a, 32'd0);
    chk("lui_b", out_b, 32'h1234);
    chk("lui_wr_reg", 32'(out_wr_reg), 32'd8);
    push(32'hFC000000, 32'd1, 32'd2);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_wr_en", 32'(out_wr_en), 32'd0);
    tick();

    // back-pressure: third push must wait until EX drains
    out_ready = 1'b0;
    drive(32'h012A4020, 32'd11, 32'd12); tick();
    drive(32'h2128FFFF, 32'd13, 32'd0);  tick();
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    drive(32'h3528FFFF, 32'd14, 32'd0);  tick();
    chk("stall_head", 32'(out_aluop), 32'(`ALU_ADD));
    out_ready = 1'b1;
    tick();
    chk("drain_second", 32'(out_aluop), 32'(`ALU_ADDI));
    tick();
    in_valid = 1'b0;
    chk("drain_third", 32'(out_aluop), 32'(`ALU_ORI));
    tick();
    chk("drain_empty", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    drive(32'h012A4020, 32'd1, 32'd2); tick();
    drive(32'h2128FFFF, 32'd3, 32'd0); tick();
    drive(32'h3C081234, 32'd0, 32'd0);
    flush = 1'b1;
    tick();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush_after", 32'(out_valid), 32'd0);

    drive(32'h012A4020, 32'd1, 32'd2); tick();
    drive(32'h2128FFFF, 32'd3, 32'd0); tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async");
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rnd_instr();
      in_rs_val = $urandom;
      in_rt_val = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
